pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL's rst/locked interface; runs on the free-running 50 MHz reference clock, never on a PLL output.
- Drives the PLL reset and watches its lock indication.
- Releases the system reset for the PLL-clocked WS2812 logic only after lock has been continuously stable.
- Retries on lock timeout, re-sequences on loss of lock or on software request, and reports status.

Parameters:
RST_HOLD_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT_CYCLES, 50000, refclk cycles to wait for lock before retry (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release
RETRY_W, 8, width of saturating retry counter

Ports:
refclk  input  1  free-running reference clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL locked flag, asynchronous to refclk
soft_rst_req  input  1  refclk-synchronous request to re-sequence, level-sampled each cycle
pll_rst  output  1  active-high reset to the PLL
sys_rst_n  output  1  active-low system reset; each PLL clock domain re-synchronizes its deassertion locally
ready  output  1  high while in RUN
state  output  2  0=RESET_PLL, 1=WAIT_LOCK, 2=STABILIZE, 3=RUN
retry_count  output  RETRY_W  lock-timeout count, saturating
timeout_pulse  output  1  one-cycle pulse per lock timeout

Behaviour:
- Reset is asynchronous, active-low (rst_n). While rst_n=0:
  - state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, retry_count=0, timeout_pulse=0.
  - Internal counter and synchronizer flops are cleared.
- pll_locked passes through a 2-flop synchronizer to give locked_s, which has 2 cycles of latency. Only locked_s is used.
- One counter, width $clog2 of the largest cycle parameter. It clears to 0 on every state entry and increments each cycle in the state.
- A state lasting N cycles exits on the edge where counter==N-1.
- All outputs are registered and decoded from next_state. They change on the same edge as state:
  - pll_rst = (next_state==RESET_PLL)
  - sys_rst_n = ready = (next_state==RUN)
- RESET_PLL:
  - Exits to WAIT_LOCK after RST_HOLD_CYCLES cycles.
  - pll_rst is high for exactly RST_HOLD_CYCLES edges after rst_n release.
- WAIT_LOCK:
  - If locked_s=1, go to STABILIZE.
  - Otherwise, at counter==LOCK_TIMEOUT_CYCLES-1, go to RESET_PLL, increment retry_count (saturating at all-ones) and pulse timeout_pulse for 1 cycle.
  - Lock in the timeout cycle takes priority; no retry is counted.
- STABILIZE:
  - If locked_s=0, go to WAIT_LOCK with the counter cleared and no retry increment.
  - Otherwise, at counter==STABLE_CYCLES-1, go to RUN.
- RUN:
  - Holds while locked_s=1.
  - If locked_s=0, go to RESET_PLL (full relock) with no retry increment.
  - sys_rst_n falls on the first edge at which locked_s is observed low, i.e. within 3 refclk edges of pll_locked falling.
- soft_rst_req=1 takes priority over all other transitions in every state.
  - Next state is RESET_PLL with the counter cleared, so a request during RESET_PLL restarts the hold count.
  - retry_count is not changed.
  - A held request keeps the block in RESET_PLL.
- retry_count is cleared only by rst_n.
- rst_n asserted mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
1. Power-up: rst_n low 5 cycles, pll_locked tied 1, defaults -> pll_rst high 16 edges, WAIT_LOCK 1 cycle, STABILIZE 1024 cycles. sys_rst_n and ready rise on edge 1041 after release; state=3.
2. Lock timeout: LOCK_TIMEOUT_CYCLES=100, pll_locked=0 -> timeout_pulse every 116 cycles, 1 cycle wide; pll_rst re-high 16 cycles each time. retry_count counts 1,2,...; after 300 timeouts it holds at 255.
3. Glitch: pll_locked drops for 3 cycles at STABILIZE count 500 -> state returns to WAIT_LOCK, then to STABILIZE. The full 1024-cycle count restarts; sys_rst_n stays 0; retry_count unchanged.
4. Loss in RUN: pll_locked falls -> sys_rst_n=0 and ready=0 within 3 edges; state=0, pll_rst high 16 cycles; relock proceeds as in scenario 1 with no retry increment.
5. Soft reset: 1-cycle soft_rst_req in RUN -> next edge state=0, sys_rst_n=0. A second request at RESET_PLL count 10 -> pll_rst stays high 16 more cycles from that point.
6. Async reset mid-STABILIZE with retry_count=3 -> without waiting for a clock edge: pll_rst=1, sys_rst_n=0, retry_count=0, state=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset and lock qualification on the free-running reference clock,
// releasing the PLL-domain system reset only after lock has held steadily.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned RETRY_W             = 8
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_rst_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic [1:0]         state,
  output logic [RETRY_W-1:0] retry_count,
  output logic               timeout_pulse
);

  localparam int unsigned MaxA = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                 RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxA > STABLE_CYCLES) ? MaxA : STABLE_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] HoldLast    = CntW'(RST_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StResetPll  = 2'd0,
    StWaitLock  = 2'd1,
    StStabilize = 2'd2,
    StRun       = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                timeout_q, timeout_d;
  logic                pll_rst_q, pll_rst_d;
  logic                run_q, run_d;
  logic                sync1_q, locked_s_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    retry_d   = retry_q;
    timeout_d = 1'b0;

    // A software request overrides every other transition, including lock loss.
    if (soft_rst_req) begin
      state_d = StResetPll;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (cnt_q == HoldLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end
        StWaitLock: begin
          if (locked_s_q) begin
            state_d = StStabilize;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            state_d   = StResetPll;
            cnt_d     = '0;
            timeout_d = 1'b1;
            if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
          end
        end
        StStabilize: begin
          if (!locked_s_q) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          if (!locked_s_q) begin
            state_d = StResetPll;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StResetPll;
          cnt_d   = '0;
        end
      endcase
    end

    pll_rst_d = (state_d == StResetPll);
    run_d     = (state_d == StRun);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StResetPll;
      cnt_q      <= '0;
      retry_q    <= '0;
      timeout_q  <= 1'b0;
      pll_rst_q  <= 1'b1;
      run_q      <= 1'b0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      timeout_q  <= timeout_d;
      pll_rst_q  <= pll_rst_d;
      run_q      <= run_d;
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = run_q;
  assign ready         = run_q;
  assign state         = state_q;
  assign retry_count   = retry_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; lock timeout shortened to 100 cycles.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] retry_count;
  logic       timeout_pulse;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (16),
    .LOCK_TIMEOUT_CYCLES(100),
    .STABLE_CYCLES      (1024),
    .RETRY_W            (8)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .state        (state),
    .retry_count  (retry_count),
    .timeout_pulse(timeout_pulse)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  // Advance n active edges and sample 1 ns later.
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; soft_rst_req = 1'b0;
    tick(5);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin errors++;
      $display("FAIL reset_sys got=%b/%b exp=0/0", sys_rst_n, ready); end
    checks++; if (retry_count !== 8'd0 || timeout_pulse !== 1'b0) begin errors++;
      $display("FAIL reset_retry got=%0d/%b exp=0/0", retry_count, timeout_pulse); end
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    tick(15);
    checks++; if (pll_rst !== 1'b1 || state !== 2'd0) begin errors++;
      $display("FAIL pu_edge15 got=%b/%0d exp=1/0", pll_rst, state); end
    tick(1);
    checks++; if (pll_rst !== 1'b0 || state !== 2'd1) begin errors++;
      $display("FAIL pu_edge16 got=%b/%0d exp=0/1", pll_rst, state); end
    tick(1);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pu_edge17 got=%0d exp=2", state); end
    tick(1023);
    checks++; if (state !== 2'd2 || sys_rst_n !== 1'b0) begin errors++;
      $display("FAIL pu_edge1040 got=%0d/%b exp=2/0", state, sys_rst_n); end
    tick(1);
    checks++; if (state !== 2'd3 || sys_rst_n !== 1'b1 || ready !== 1'b1) begin errors++;
      $display("FAIL pu_edge1041 got=%0d/%b/%b exp=3/1/1", state, sys_rst_n, ready); end
  endtask

  task automatic test_loss_in_run();
    pll_locked = 1'b0;
    tick(2);
    checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_edge2 got=%b exp=1", sys_rst_n); end
    tick(1);
    checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0 || state !== 2'd0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL loss_edge3 got=%b/%b/%0d/%b exp=0/0/0/1", sys_rst_n, ready, state, pll_rst); end
    pll_locked = 1'b1;
    tick(15);
    checks++; if (pll_rst !== 1'b1 || state !== 2'd0) begin errors++;
      $display("FAIL loss_hold got=%b/%0d exp=1/0", pll_rst, state); end
    tick(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL loss_wait got=%0d exp=1", state); end
    tick(1);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL loss_stab got=%0d exp=2", state); end
    tick(1023);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL loss_stab_end got=%0d exp=2", state); end
    tick(1);
    checks++; if (state !== 2'd3 || ready !== 1'b1 || retry_count !== 8'd0) begin errors++;
      $display("FAIL loss_relock got=%0d/%b/%0d exp=3/1/0", state, ready, retry_count); end
  endtask

  task automatic test_soft_reset();
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    checks++; if (state !== 2'd0 || sys_rst_n !== 1'b0 || pll_rst !== 1'b1) begin errors++;
      $display("FAIL soft_enter got=%0d/%b/%b exp=0/0/1", state, sys_rst_n, pll_rst); end
    tick(10);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(15);
    checks++; if (pll_rst !== 1'b1 || state !== 2'd0) begin errors++;
      $display("FAIL soft_restart_hold got=%b/%0d exp=1/0", pll_rst, state); end
    tick(1);
    checks++; if (pll_rst !== 1'b0 || state !== 2'd1) begin errors++;
      $display("FAIL soft_restart_exit got=%b/%0d exp=0/1", pll_rst, state); end
    tick(1025);
    checks++; if (state !== 2'd3 || retry_count !== 8'd0) begin errors++;
      $display("FAIL soft_relock got=%0d/%0d exp=3/0", state, retry_count); end
  endtask

  task automatic test_glitch();
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(517);
    pll_locked = 1'b0;
    tick(2);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_pre got=%0d exp=2", state); end
    tick(1);
    checks++; if (state !== 2'd1 || sys_rst_n !== 1'b0) begin errors++;
      $display("FAIL glitch_drop got=%0d/%b exp=1/0", state, sys_rst_n); end
    pll_locked = 1'b1;
    tick(3);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_back got=%0d exp=2", state); end
    tick(1023);
    checks++; if (state !== 2'd2 || sys_rst_n !== 1'b0) begin errors++;
      $display("FAIL glitch_recount got=%0d/%b exp=2/0", state, sys_rst_n); end
    tick(1);
    checks++; if (state !== 2'd3 || retry_count !== 8'd0) begin errors++;
      $display("FAIL glitch_run got=%0d/%0d exp=3/0", state, retry_count); end
  endtask

  task automatic test_timeout();
    pll_locked = 1'b0;
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(115);
    checks++; if (state !== 2'd1 || timeout_pulse !== 1'b0) begin errors++;
      $display("FAIL to_before got=%0d/%b exp=1/0", state, timeout_pulse); end
    tick(1);
    checks++; if (timeout_pulse !== 1'b1 || retry_count !== 8'd1 || state !== 2'd0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL to_first got=%b/%0d/%0d/%b exp=1/1/0/1", timeout_pulse, retry_count, state, pll_rst); end
    tick(1);
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_width got=%b exp=0", timeout_pulse); end
    tick(14);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL to_hold got=%b exp=1", pll_rst); end
    tick(1);
    checks++; if (pll_rst !== 1'b0 || state !== 2'd1) begin errors++;
      $display("FAIL to_hold_end got=%b/%0d exp=0/1", pll_rst, state); end
    tick(100);
    checks++; if (timeout_pulse !== 1'b1 || retry_count !== 8'd2) begin errors++;
      $display("FAIL to_second got=%b/%0d exp=1/2", timeout_pulse, retry_count); end
    tick(116 * 253);
    checks++; if (timeout_pulse !== 1'b1 || retry_count !== 8'd255) begin errors++;
      $display("FAIL to_255 got=%b/%0d exp=1/255", timeout_pulse, retry_count); end
    tick(116 * 45);
    checks++; if (timeout_pulse !== 1'b1 || retry_count !== 8'd255) begin errors++;
      $display("FAIL to_saturate got=%b/%0d exp=1/255", timeout_pulse, retry_count); end
  endtask

  task automatic test_async_reset();
    #5 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(348);
    checks++; if (retry_count !== 8'd3 || timeout_pulse !== 1'b1) begin errors++;
      $display("FAIL ar_retry3 got=%0d/%b exp=3/1", retry_count, timeout_pulse); end
    pll_locked = 1'b1;
    tick(200);
    checks++; if (state !== 2'd2 || retry_count !== 8'd3) begin errors++;
      $display("FAIL ar_stab got=%0d/%0d exp=2/3", state, retry_count); end
    #5 rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || retry_count !== 8'd0 ||
                  state !== 2'd0) begin errors++;
      $display("FAIL ar_async got=%b/%b/%b/%0d/%0d exp=1/0/0/0/0", pll_rst, sys_rst_n, ready,
               retry_count, state); end
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_loss_in_run();
    test_soft_reset();
    test_glitch();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
